pattern_serializer: RTL
=======================

Name: pattern_serializer

Overview:
Transmit-side counterpart to the team's serial sequence detectors. Accepts a parallel bit pattern plus length and repeat count, then emits it MSB-first on a single serial line, one bit per clock. Drives detector benches and on-chip serial links. Between repetitions and when idle, the line holds a programmable idle level.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of len input; must hold the value WIDTH
CNT_W, 4, width of repeat count input
IDLE_LEVEL, 1'b1, serial line level when no bit is being sent

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to send; sampled only when ready=1
pattern  input  WIDTH  bits to send; pattern[len-1] is sent first, pattern[0] last
len  input  LEN_W  number of bits per repetition, valid range 1..WIDTH
reps  input  CNT_W  number of repetitions, valid range 1..2^CNT_W-1
ready  output  1  high in IDLE; start is accepted only when ready=1
busy  output  1  high from acceptance until done
A_out  output  1  registered serial data
bit_valid  output  1  high on cycles where A_out carries a pattern bit
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, A_out=IDLE_LEVEL, bit_valid=0, done=0, busy=0, ready=1.
  - All internal registers are cleared.
- States: IDLE, SHIFT, GAP, DONE.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- IDLE: ready=1, A_out=IDLE_LEVEL.
  - If start=1, len in 1..WIDTH and reps!=0 at edge N:
    - Capture pattern left-aligned so that pattern[len-1] sits at shift-register MSB.
    - Set bit_cnt=len-1 and reps_left=reps.
    - Enter SHIFT; the first bit is on A_out with bit_valid=1 after edge N.
  - If len==0, len>WIDTH or reps==0: the request is ignored; stay in IDLE, no done pulse.
- SHIFT: A_out=shift MSB, bit_valid=1, and the register shifts left each edge.
  - When bit_cnt==0 and reps_left>1: go to GAP and decrement reps_left.
  - When bit_cnt==0 and reps_left==1: go to DONE.
  - Otherwise decrement bit_cnt.
- GAP: exactly one cycle with A_out=IDLE_LEVEL and bit_valid=0.
  - Reload the shift register from the captured copy of the pattern (not the live input) and set bit_cnt=len-1.
  - Return to SHIFT.
- DONE: one cycle with done=1, busy=0, ready=0, A_out=IDLE_LEVEL, then IDLE.
- Latency and total length:
  - The first bit appears 1 cycle after the accepting edge.
  - Total busy cycles = reps*len + (reps-1).
  - done rises on the cycle after the last bit.
- start while busy or in DONE is ignored; it is not queued.
- Changes to pattern/len/reps after acceptance have no effect on the transfer in progress.
- Back-to-back transfers: start asserted in the cycle IDLE is re-entered is accepted, giving a minimum 1-cycle idle gap after DONE.
- rst mid-transfer: immediately returns to the reset values. No done pulse and no partial completion.
- len==WIDTH: the full register is sent with no wrap error. len==1: a single bit per repetition.

Decomposition:
- Shared package holds:
  - The state encoding constants (S_IDLE=2'b00, S_SHIFT=2'b01, S_GAP=2'b10, S_DONE=2'b11).
  - The IDLE_LEVEL default.
  - The same package also holds detector state codes so the paired benches share one definition.
- One sub-module is natural: shift_reg_load (WIDTH-bit left-shift register with parallel load and MSB output).
- The FSM, counters and argument validation stay in the top module.

Test Plan:
- Reset then pattern=8'b0000_0001, len=2, reps=1, start pulse -> A_out sequence 0,1 on 2 cycles with bit_valid=1, then done=1 for 1 cycle, A_out=1 thereafter.
- pattern=8'b1011_0010, len=8, reps=1 -> A_out 1,0,1,1,0,0,1,0 MSB-first, busy 8 cycles, done on cycle 9.
- pattern=3'b010, len=3, reps=3 -> 0,1,0,idle(1),0,1,0,idle(1),0,1,0, then done; total 11 busy cycles. A paired detector sees three "01" events.
- Invalid arguments: len=0 or reps=0 with start=1 -> ready stays 1, bit_valid never rises, no done.
- start re-pulsed mid-transfer with a different pattern -> ignored; the original bitstream is unchanged.
- rst asserted on the 3rd bit of an 8-bit send -> A_out=1, bit_valid=0, busy=0 immediately (asynchronously), no done. A new start after release works normally.

Source files
------------

// File: rtl/pattern_serializer_pkg.sv
// pattern_serializer_pkg
//   Definitions shared by the pattern serializer and the serial sequence
//   detectors it drives. Keeping both state encodings here gives the paired
//   benches a single source for state codes and the default idle level.
package pattern_serializer_pkg;

  // Serializer FSM encoding. Debug tooling decodes these fixed values,
  // so the encoding is explicit.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } ser_state_t;

  // Level the serial line rests at when no pattern bit is being sent.
  localparam logic IDLE_LEVEL_DEF = 1'b1;

  // Detector encoding, shared with the receive-side "01" sequence detector.
  typedef enum logic [1:0] {
    D_WAIT = 2'b00,   // no partial match
    D_SAW0 = 2'b01,   // last bit was 0
    D_HIT  = 2'b10    // "01" just completed
  } det_state_t;

endpackage

// File: rtl/pattern_serializer_shift_reg_load.sv
// pattern_serializer_shift_reg_load
//   WIDTH-bit left-shift register with parallel load. The MSB is the bit
//   currently presented on the serial line. Load wins over shift.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears the register
//   load  - load din on the next edge
//   shift - shift left by one (zero fill) on the next edge
//   din   - parallel load value, already left-aligned by the caller
//   msb   - current register MSB
module pattern_serializer_shift_reg_load #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer
//   Sends a parallel pattern MSB-first on a single serial line, one bit per
//   clock, repeated reps times with a one-cycle idle gap between repetitions.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a request; line at idle level
//   S_SHIFT | a pattern bit is on A_out (bit_valid=1)
//   S_GAP   | one idle cycle between repetitions; shift register reloads
//   S_DONE  | one-cycle done pulse; requests ignored
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - send request, only sampled while ready=1
//   pattern   - bits to send; pattern[len-1] goes out first
//   len       - bits per repetition, 1..WIDTH
//   reps      - repetitions, nonzero
//   ready     - idle and able to accept start
//   busy      - transfer in progress (bits and gaps)
//   A_out     - serial data
//   bit_valid - A_out carries a pattern bit this cycle
//   done      - one-cycle pulse after the last bit
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   LEN_W      = 4,
  parameter int   CNT_W      = 4,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  output logic             ready,
  output logic             busy,
  output logic             A_out,
  output logic             bit_valid,
  output logic             done
);

  ser_state_t       state, state_nx;
  logic [LEN_W-1:0] bit_cnt, bit_cnt_nx;
  logic [CNT_W-1:0] reps_left, reps_left_nx;
  logic [LEN_W-1:0] len_q;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] sr_din;
  logic             sr_load, sr_shift, sr_msb;
  logic             capture;
  logic             args_ok;

  // Left-align so pattern[len-1] lands on the shift-register MSB. Only
  // meaningful when len is in range; out-of-range requests are rejected.
  always_comb begin
    aligned = pattern << (WIDTH - int'(len));
  end

  assign args_ok = (len != '0) && (int'(len) <= WIDTH) && (reps != '0);

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    reps_left_nx = reps_left;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_din       = pat_q;
    capture      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && args_ok) begin
          state_nx     = S_SHIFT;
          capture      = 1'b1;
          sr_load      = 1'b1;
          sr_din       = aligned;
          bit_cnt_nx   = len - 1'b1;
          reps_left_nx = reps;
        end
      end
      S_SHIFT: begin
        sr_shift = 1'b1;
        if (bit_cnt == '0) begin
          if (reps_left > CNT_W'(1)) begin
            state_nx     = S_GAP;
            reps_left_nx = reps_left - 1'b1;
          end else begin
            state_nx = S_DONE;
          end
        end else begin
          bit_cnt_nx = bit_cnt - 1'b1;
        end
      end
      S_GAP: begin
        // Reload from the captured copy so live inputs cannot disturb
        // later repetitions.
        sr_load    = 1'b1;
        sr_din     = pat_q;
        bit_cnt_nx = len_q - 1'b1;
        state_nx   = S_SHIFT;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      reps_left <= '0;
      len_q     <= '0;
      pat_q     <= '0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      reps_left <= reps_left_nx;
      if (capture) begin
        len_q <= len;
        pat_q <= aligned;
      end
    end
  end

  pattern_serializer_shift_reg_load #(
    .WIDTH (WIDTH)
  ) u_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  // Outputs decode the registered state (and register MSB) only, so there
  // is no input-to-output combinational path and reset acts immediately.
  assign ready     = (state == S_IDLE);
  assign busy      = (state == S_SHIFT) || (state == S_GAP);
  assign bit_valid = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign A_out     = (state == S_SHIFT) ? sr_msb : IDLE_LEVEL;

endmodule
